// File: rtl/fm_mot_param_loader.sv
// fm_mot_param_loader
//
// Decodes checksummed frames from the touchscreen byte link. It writes FM_MOT
// parameters into the per-mode bank, or it selects the active FM_MOT mode.
// Each complete frame gets a one-byte ACK/NAK.
//
// Frames:
//   write    : A5 CMD IDX D2 D1 D0 CHK  (data MSB first)
//   set mode : A5 CMD CHK
//   CMD[7:6] type (00 write, 01 set mode, 1x illegal), CMD[1:0] mode.
//   CHK is the XOR of all bytes between SOF and CHK.
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   rx_valid_i/rx_data_i      incoming byte, accepted when rx_ready_o is high
//   rx_ready_o                loader can take a byte (low while a response is pending)
//   tx_valid_o/tx_data_o      response byte (5A ACK, E1 checksum NAK, E2 cmd/index NAK)
//   tx_ready_i                response consumed when tx_valid_o && tx_ready_i
//   wr_en_o                   one-cycle parameter write strobe
//   wr_mode_o/idx_o/data_o    write target and raw 24-bit value, held until next write
//   mode_o                    active FM_MOT mode
//   err_cnt_o                 saturating count of bad frames and timeouts

module fm_mot_param_loader #(
    parameter int unsigned NUM_IDX = 30,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        wr_en_o,
    output logic [1:0]  wr_mode_o,
    output logic [4:0]  wr_idx_o,
    output logic [23:0] wr_data_o,
    output logic [1:0]  mode_o,
    output logic [7:0]  err_cnt_o
);

    localparam logic [7:0] Sof    = 8'hA5;
    localparam logic [7:0] Ack    = 8'h5A;
    localparam logic [7:0] NakChk = 8'hE1;
    localparam logic [7:0] NakCmd = 8'hE2;

    localparam logic [1:0] TypeWrite = 2'b00;
    localparam logic [1:0] TypeMode  = 2'b01;

    localparam int unsigned    TmoW    = $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    // StEval is the cycle between taking CHK and presenting the outcome; all
    // frame effects appear together one cycle after CHK is accepted.
    typedef enum logic [3:0] {
        StIdle,
        StCmd,
        StIdx,
        StD2,
        StD1,
        StD0,
        StChk,
        StEval,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      type_q, type_d;
    logic [1:0]      cmode_q, cmode_d;
    logic [7:0]      idx_q, idx_d;
    logic [23:0]     data_q, data_d;
    logic [7:0]      xor_q, xor_d;
    logic [7:0]      chk_q, chk_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            wr_en_q, wr_en_d;
    logic [1:0]      wr_mode_q, wr_mode_d;
    logic [4:0]      wr_idx_q, wr_idx_d;
    logic [23:0]     wr_data_q, wr_data_d;
    logic [1:0]      mode_q, mode_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic rx_ready;
    logic rx_fire;
    logic timed;
    logic err_inc;
    logic idx_big;

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        cmode_d   = cmode_q;
        idx_d     = idx_q;
        data_d    = data_q;
        xor_d     = xor_q;
        chk_d     = chk_q;
        tmo_d     = tmo_q;
        tx_data_d = tx_data_q;
        wr_en_d   = 1'b0;
        wr_mode_d = wr_mode_q;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        mode_d    = mode_q;
        err_inc   = 1'b0;

        rx_ready = (state_q != StEval) && (state_q != StResp);
        rx_fire  = rx_valid_i && rx_ready;
        timed    = (state_q == StCmd) || (state_q == StIdx) || (state_q == StD2) ||
                   (state_q == StD1) || (state_q == StD0) || (state_q == StChk);
        // Full 8-bit index compare so out-of-range bytes never alias into 0..31.
        idx_big  = 32'(idx_q) >= NUM_IDX;

        unique case (state_q)
            StIdle: begin
                if (rx_fire && rx_data_i == Sof) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (rx_fire) begin
                    type_d  = rx_data_i[7:6];
                    cmode_d = rx_data_i[1:0];
                    xor_d   = rx_data_i;
                    // Illegal types are only rejected at CHK, so they take the long path.
                    state_d = (rx_data_i[7:6] == TypeMode) ? StChk : StIdx;
                end
            end
            StIdx: begin
                if (rx_fire) begin
                    idx_d   = rx_data_i;
                    xor_d   = xor_q ^ rx_data_i;
                    state_d = StD2;
                end
            end
            StD2: begin
                if (rx_fire) begin
                    data_d[23:16] = rx_data_i;
                    xor_d         = xor_q ^ rx_data_i;
                    state_d       = StD1;
                end
            end
            StD1: begin
                if (rx_fire) begin
                    data_d[15:8] = rx_data_i;
                    xor_d        = xor_q ^ rx_data_i;
                    state_d      = StD0;
                end
            end
            StD0: begin
                if (rx_fire) begin
                    data_d[7:0] = rx_data_i;
                    xor_d       = xor_q ^ rx_data_i;
                    state_d     = StChk;
                end
            end
            StChk: begin
                if (rx_fire) begin
                    chk_d   = rx_data_i;
                    state_d = StEval;
                end
            end
            StEval: begin
                state_d = StResp;
                if (chk_q != xor_q) begin
                    tx_data_d = NakChk;
                    err_inc   = 1'b1;
                end else if (type_q[1] || (type_q == TypeWrite && idx_big)) begin
                    tx_data_d = NakCmd;
                    err_inc   = 1'b1;
                end else begin
                    tx_data_d = Ack;
                    if (type_q == TypeWrite) begin
                        wr_en_d   = 1'b1;
                        wr_mode_d = cmode_q;
                        wr_idx_d  = idx_q[4:0];
                        wr_data_d = data_q;
                    end else begin
                        mode_d = cmode_q;
                    end
                end
            end
            StResp: begin
                if (tx_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Inter-byte timeout: counts idle cycles inside a frame, drops the frame silently.
        if (timed && !rx_fire) begin
            if (tmo_q == TmoLast) begin
                state_d = StIdle;
                err_inc = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end else begin
            tmo_d = '0;
        end

        err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            type_q    <= '0;
            cmode_q   <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            xor_q     <= '0;
            chk_q     <= '0;
            tmo_q     <= '0;
            tx_data_q <= '0;
            wr_en_q   <= 1'b0;
            wr_mode_q <= '0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            mode_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            cmode_q   <= cmode_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            xor_q     <= xor_d;
            chk_q     <= chk_d;
            tmo_q     <= tmo_d;
            tx_data_q <= tx_data_d;
            wr_en_q   <= wr_en_d;
            wr_mode_q <= wr_mode_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            mode_q    <= mode_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rx_ready_o = rx_ready;
    assign tx_valid_o = (state_q == StResp);
    assign tx_data_o  = tx_data_q;
    assign wr_en_o    = wr_en_q;
    assign wr_mode_o  = wr_mode_q;
    assign wr_idx_o   = wr_idx_q;
    assign wr_data_o  = wr_data_q;
    assign mode_o     = mode_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: doc/fm_mot_param_loader.md
# fm_mot_param_loader

Byte-stream frame decoder that writes FM_MOT parameters from the touchscreen link into the per-mode parameter bank and sets the active FM_MOT mode. It sits between the touchscreen byte receiver and the four mode parameter sets (modes 0-3) that feed the FM_MOT parameter selector. It validates each frame by checksum and returns a one-byte ACK/NAK with a valid/ready handshake.

## Interface
- NUM_IDX, 30: number of parameters per mode; valid indices are 0..NUM_IDX-1.
- TIMEOUT, 1000000: maximum idle clk cycles between bytes inside a frame.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  rx_data is valid; a byte is accepted when rx_valid && rx_ready.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader can accept a byte.
- tx_valid  out  1  response byte pending.
- tx_data  out  8  response byte: 0x5A ACK, 0xE1 checksum NAK, 0xE2 command/index NAK.
- tx_ready  in  1  consumer takes tx_data when tx_valid && tx_ready.
- wr_en  out  1  one-cycle parameter write strobe.
- wr_mode  out  2  target mode set for the write.
- wr_idx  out  5  parameter index.
- wr_data  out  24  raw value; consumers of narrower parameters take the low bits.
- mode  out  2  active FM_MOT mode, which drives the selector's mode input.
- err_cnt  out  8  frame error count, saturating at 255.

## Operation
- Write frame, 7 bytes: SOF 0xA5, CMD, IDX, D2, D1, D0, CHK. The data bytes are sent MSB first.
- Set-mode frame, 3 bytes: SOF 0xA5, CMD, CHK.
- CMD[7:6] gives the frame type: 00 = write, 01 = set mode, 10 and 11 are illegal. CMD[1:0] gives the mode. CMD[5:2] are ignored.
- CHK is the XOR of every byte after SOF and before CHK. For set-mode frames, CHK equals CMD.
- An illegal type is not known until CHK arrives. The decoder therefore uses the 7-byte write frame length for types 10 and 11.
- States:
  - IDLE: a byte equal to 0xA5 moves to CMD. Any other byte is dropped silently and is not counted as an error.
  - CMD: latch CMD and start the running XOR. Type 01 moves to CHK; every other type moves to IDX.
  - IDX, D2, D1, D0: latch each byte and XOR it into the checksum, then advance in that order. D0 moves to CHK.
  - CHK: evaluate the frame. The NAK checks below are applied in order and the first match wins.
    - CHK ≠ computed XOR: respond 0xE1, increment err_cnt.
    - Type 10 or 11, or (type 00 and IDX ≥ NUM_IDX): respond 0xE2, increment err_cnt.
    - Otherwise, type 00: pulse wr_en.
    - Otherwise, type 01: update mode.
    - Every good frame responds with 0x5A.
    - All outcomes move to RESP.
  - RESP: tx_valid is high and tx_data is held stable. Move to IDLE on tx_valid && tx_ready.
- rx_ready is 1 in every state except RESP, where it is 0. Bytes offered during RESP are not consumed.
- Timeout:
  - Applies in states CMD, IDX, D2, D1, D0 and CHK.
  - A counter is cleared on each accepted byte.
  - When the counter reaches TIMEOUT, return to IDLE and increment err_cnt. No response is sent.
  - Counter width is $clog2(TIMEOUT+1).
- No mode or wr_* change occurs on a bad frame or on a timeout.
- err_cnt saturates at 255 and does not wrap.

## Timing
- Reset values: rx_ready=1, tx_valid=0, tx_data=0x00, wr_en=0, wr_mode=0, wr_idx=0, wr_data=0, mode=0, err_cnt=0, state=IDLE.
- Latency: CHK is accepted on edge N. On edge N+1, the following take effect together:
  - wr_en=1, with wr_mode, wr_idx and wr_data valid;
  - any change to mode;
  - any err_cnt increment;
  - tx_valid=1 with tx_data.
- wr_en is high for exactly one cycle. wr_mode, wr_idx and wr_data hold their values until the next write.
- After the response handshake on edge M, rx_ready=1 from M+1. Minimum spacing between frame starts is therefore frame length + 2 cycles.
- A byte can be accepted every cycle. rx_valid may be held high continuously.
- Reset asserted mid-frame or in RESP:
  - Takes effect immediately (asynchronously) and forces all reset values.
  - Any partial frame is discarded.
  - mode returns to 0.

## Test plan
- Good write: send A5 02 05 00 12 34 21. Expect one wr_en pulse with wr_mode=2, wr_idx=5, wr_data=0x001234, then tx 0x5A. mode stays 0 and err_cnt stays 0.
- Set mode: send A5 43 43. Expect mode=3 one cycle after CHK, tx 0x5A, and no wr_en.
- Bad checksum, then bad index:
  - Send A5 02 05 00 12 34 20. Expect tx 0xE1, err_cnt=1, no wr_en.
  - Send A5 00 1E 00 00 01 1F. Expect tx 0xE2, err_cnt=2.
- Backpressure: hold tx_ready=0 for 10 cycles after a good frame. Expect tx_valid=1, tx_data=0x5A stable, and rx_ready=0 while offering 0xA5. After the handshake, rx_ready=1 on the next cycle, and the next full frame is accepted normally.
- Timeout and garbage: with TIMEOUT=16, send 33 A5 02, then idle 16 cycles. Expect IDLE, err_cnt+1, and no tx. A following good write is accepted.
- Reset mid-frame: after A5 43, pulse rst_n low. Expect all outputs at reset values. A following A5 41 41 sets mode=1.
